// File: rtl/stall_ctrl.sv
// Pipeline hazard controller: Tuse/Tnew data stalls plus a mult/div busy tracker.
// Optional stall performance counter enabled by defining STALL_PERF_EN.
module stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic [1:0]  Tuse_rs_ID,
  input  logic [1:0]  Tuse_rt_ID,
  input  logic        RegWrite_EX,
  input  logic        RegWrite_MEM,
  input  logic [4:0]  A3_EX,
  input  logic [4:0]  A3_MEM,
  input  logic [1:0]  Tnew_EX,
  input  logic [1:0]  Tnew_MEM,
  input  logic        MD_ID,
  input  logic        Start_EX,
  input  logic        MDOp_EX,
  output logic        En_PC,
  output logic        En_IF_ID,
  output logic        Clr_ID_EX,
  output logic        Busy,
  output logic [31:0] Stall_Cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] load_next;
  logic             busy_reg;

  logic [4:0] src  [2];
  logic [1:0] tuse [2];
  logic [1:0] op_stall;
  logic       md_stall;
  logic       stall;

  assign src[0]  = Rs_ID;
  assign src[1]  = Rt_ID;
  assign tuse[0] = Tuse_rs_ID;
  assign tuse[1] = Tuse_rt_ID;

  // Tuse = 3 can never be below a 2-bit Tnew, so unused operands drop out naturally.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      logic hit_ex;
      logic hit_mem;
      assign hit_ex  = RegWrite_EX  && (A3_EX  == src[gi]) && (tuse[gi] < Tnew_EX);
      assign hit_mem = RegWrite_MEM && (A3_MEM == src[gi]) && (tuse[gi] < Tnew_MEM);
      assign op_stall[gi] = (src[gi] != 5'd0) && (hit_ex || hit_mem);
    end
  endgenerate

  assign md_stall = MD_ID && (Start_EX || busy_reg);
  // Reset forces the pipeline free-running regardless of hazard inputs.
  assign stall    = !reset && ((|op_stall) || md_stall);

  assign En_PC     = !stall;
  assign En_IF_ID  = !stall;
  assign Clr_ID_EX = stall;
  assign Busy      = busy_reg;

  assign load_next = MDOp_EX ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start_EX) begin
            state_reg <= BUSY;
            cnt_reg   <= load_next;
            busy_reg  <= 1'b1;
          end
        end
        BUSY: begin
          // A Start arriving here is ignored; the count is never reloaded mid-operation.
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= 32'd0;
    end else if (stall) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign Stall_Cnt = stall_cnt_reg;
`else
  assign Stall_Cnt = 32'd0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: expectations queued per cycle, compared at negedge.
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Rs_ID, Rt_ID, A3_EX, A3_MEM;
  logic [1:0]  Tuse_rs_ID, Tuse_rt_ID, Tnew_EX, Tnew_MEM;
  logic        RegWrite_EX, RegWrite_MEM, MD_ID, Start_EX, MDOp_EX;
  logic        En_PC, En_IF_ID, Clr_ID_EX, Busy;
  logic [31:0] Stall_Cnt;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  typedef struct packed {
    logic        en_pc;
    logic        en_if_id;
    logic        clr;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int          m_busy = 0;   // reference busy countdown
  logic [31:0] m_perf = 0;   // reference stall counter

  stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Tuse_rs_ID(Tuse_rs_ID), .Tuse_rt_ID(Tuse_rt_ID),
    .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM),
    .A3_EX(A3_EX), .A3_MEM(A3_MEM), .Tnew_EX(Tnew_EX), .Tnew_MEM(Tnew_MEM),
    .MD_ID(MD_ID), .Start_EX(Start_EX), .MDOp_EX(MDOp_EX),
    .En_PC(En_PC), .En_IF_ID(En_IF_ID), .Clr_ID_EX(Clr_ID_EX),
    .Busy(Busy), .Stall_Cnt(Stall_Cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s txn=%0d obs=%0h exp=%0h", tag, txn, obs, exp);
    end
  endtask

  function automatic bit hz(input logic [4:0] r, input logic [1:0] tu);
    bit ex_hit, mem_hit;
    ex_hit  = RegWrite_EX  && (A3_EX  == r) && (tu < Tnew_EX);
    mem_hit = RegWrite_MEM && (A3_MEM == r) && (tu < Tnew_MEM);
    return (r != 5'd0) && (ex_hit || mem_hit);
  endfunction

  function automatic bit model_stall();
    if (reset) return 1'b0;
    return hz(Rs_ID, Tuse_rs_ID) || hz(Rt_ID, Tuse_rt_ID) ||
           (MD_ID && (Start_EX || m_busy != 0));
  endfunction

  // One clock cycle with the currently driven inputs.
  task automatic step();
    exp_t e, got;
    bit   s;
    s          = model_stall();
    e.en_pc    = !s;
    e.en_if_id = !s;
    e.clr      = s;
    e.busy     = !reset && (m_busy != 0);
`ifdef STALL_PERF_EN
    e.cnt      = reset ? 32'd0 : m_perf;
`else
    e.cnt      = 32'd0;
`endif
    exp_q.push_back(e);
    @(negedge clk);
    got = exp_q.pop_front();
    check("en_pc",    {31'd0, En_PC},     {31'd0, got.en_pc});
    check("en_if_id", {31'd0, En_IF_ID},  {31'd0, got.en_if_id});
    check("clr_id_ex",{31'd0, Clr_ID_EX}, {31'd0, got.clr});
    check("busy",     {31'd0, Busy},      {31'd0, got.busy});
    check("stall_cnt", Stall_Cnt,         got.cnt);
    $display("txn %0d rst=%0b md=%0b start=%0b stall=%0b busy=%0b cnt=%0d",
             txn, reset, MD_ID, Start_EX, Clr_ID_EX, Busy, Stall_Cnt);
    txn++;
    @(posedge clk);
    if (reset) begin
      m_busy = 0;
      m_perf = 0;
    end else begin
      if (s) m_perf = m_perf + 32'd1;
      if (m_busy != 0) m_busy = m_busy - 1;
      else if (Start_EX) m_busy = MDOp_EX ? 10 : 5;
    end
    #1;
  endtask

  task automatic idle_inputs();
    Rs_ID = 0; Rt_ID = 0; Tuse_rs_ID = 3; Tuse_rt_ID = 3;
    RegWrite_EX = 0; RegWrite_MEM = 0; A3_EX = 0; A3_MEM = 0;
    Tnew_EX = 0; Tnew_MEM = 0; MD_ID = 0; Start_EX = 0; MDOp_EX = 0;
  endtask

  task automatic load_use(input logic [1:0] tu);
    RegWrite_EX = 1; A3_EX = 8; Tnew_EX = 2; Rs_ID = 8; Tuse_rs_ID = tu;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    // Hazard and MD inputs active during reset must not stall.
    load_use(2'd1);
    MD_ID = 1; Start_EX = 1;
    #1;
    step();
    step();
    idle_inputs();
    reset = 1'b0;

    // Load-use stall, then Tuse raised to 2 clears it.
    load_use(2'd1); step();
    load_use(2'd2); step();
    // $0 destination and unused rt operand.
    idle_inputs(); RegWrite_EX = 1; A3_EX = 0; Rs_ID = 0; Tuse_rs_ID = 0; Tnew_EX = 2; step();
    idle_inputs(); RegWrite_EX = 1; A3_EX = 9; Rt_ID = 9; Tuse_rt_ID = 3; Tnew_EX = 3; step();
    // MEM-stage hazard on rt, then same with RegWrite low.
    idle_inputs(); RegWrite_MEM = 1; A3_MEM = 12; Rt_ID = 12; Tuse_rt_ID = 0; Tnew_MEM = 1; step();
    RegWrite_MEM = 0; step();
    // Random hazard patterns.
    for (int i = 0; i < 20; i++) begin
      idle_inputs();
      Rs_ID = 5'($urandom_range(0, 3)); Rt_ID = 5'($urandom_range(0, 3));
      A3_EX = 5'($urandom_range(0, 3)); A3_MEM = 5'($urandom_range(0, 3));
      Tuse_rs_ID = 2'($urandom); Tuse_rt_ID = 2'($urandom);
      Tnew_EX = 2'($urandom); Tnew_MEM = 2'($urandom);
      RegWrite_EX = 1'($urandom); RegWrite_MEM = 1'($urandom);
      step();
    end

    // Mult followed by mfhi: 6 stalled cycles, released in cycle 7.
    idle_inputs(); MD_ID = 1; Start_EX = 1; MDOp_EX = 0; step();
    Start_EX = 0;
    for (int i = 0; i < 6; i++) step();
    check("mult_released", {31'd0, Busy}, 32'd0);

    // Div with a non-MD instruction in ID: busy for 10 cycles, no stall.
    idle_inputs(); Start_EX = 1; MDOp_EX = 1; step();
    Start_EX = 0;
    for (int i = 0; i < 11; i++) step();

    // Reset during busy cycle 3 of a div; async effect checked before any edge.
    idle_inputs(); Start_EX = 1; MDOp_EX = 1; step();
    Start_EX = 0; MD_ID = 1;
    step(); step();
    reset = 1'b1; #1;
    check("async_busy", {31'd0, Busy}, 32'd0);
    check("async_en_pc", {31'd0, En_PC}, 32'd1);
    step();
    // Release reset with Start present: sampled at the first edge after release.
    reset = 1'b0; MD_ID = 0; Start_EX = 1; MDOp_EX = 0; step();
    Start_EX = 0;
    for (int i = 0; i < 6; i++) step();

    // Perf scenario: 3 load-use stalls plus mult->mfhi (6 stalls).
    idle_inputs(); reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin load_use(2'd0); step(); end
    idle_inputs(); MD_ID = 1; Start_EX = 1; step();
    Start_EX = 0;
    for (int i = 0; i < 6; i++) step();
    idle_inputs(); step();
`ifdef STALL_PERF_EN
    check("perf_total", Stall_Cnt, 32'd9);
`else
    check("perf_total", Stall_Cnt, 32'd0);
`endif

    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline hazard controller for the five-stage MIPS core: it sequences the PC register, the IF/ID pipeline register and the ID/EX register by driving their enable and clear inputs. It combines register-operand data hazards (Tuse/Tnew rule) with a multi-cycle multiply/divide busy tracker, and sits beside the ID stage, fed from ID, EX and MEM pipeline fields.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu in cycles (≥1)
- DIV_CYCLES, 10, busy duration of div/divu in cycles (≥1)
- CNT_W, 4, busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- Rs_ID, Rt_ID  in  5 each  source register numbers of the ID instruction
- Tuse_rs_ID, Tuse_rt_ID  in  2 each  cycles until operand is needed; 3 = operand unused
- RegWrite_EX, RegWrite_MEM  in  1 each  stage instruction writes GPR
- A3_EX, A3_MEM  in  5 each  destination register of stage instruction
- Tnew_EX, Tnew_MEM  in  2 each  cycles until result is available, as seen from that stage
- MD_ID  in  1  ID instruction uses the mult/div unit or HI/LO (mult*, div*, mfhi, mflo, mthi, mtlo)
- Start_EX  in  1  mult/div instruction in EX this cycle (one-cycle pulse)
- MDOp_EX  in  1  0 = mult/multu, 1 = div/divu; valid with Start_EX
- En_PC  out  1  PC write enable
- En_IF_ID  out  1  IF/ID register enable
- Clr_ID_EX  out  1  ID/EX register synchronous clear (bubble insert)
- Busy  out  1  mult/div unit busy
- Stall_Cnt  out  32  stalled-cycle count (see Configuration)

## Operation
- Data stall for operand rs: Rs_ID ≠ 0 and ((RegWrite_EX and A3_EX = Rs_ID and Tuse_rs_ID < Tnew_EX) or (RegWrite_MEM and A3_MEM = Rs_ID and Tuse_rs_ID < Tnew_MEM)). Same for rt. Comparisons unsigned 2-bit; Tuse = 3 never stalls.
- MD stall: MD_ID and (Start_EX or Busy).
- stall = data stall or MD stall. En_PC = En_IF_ID = not stall; Clr_ID_EX = stall. Purely combinational from inputs and Busy.
- Busy FSM, states IDLE (cnt = 0) and BUSY (cnt ≠ 0); Busy = (cnt ≠ 0).
  - IDLE, Start_EX = 1: cnt ← MDOp_EX ? DIV_CYCLES : MULT_CYCLES.
  - BUSY: cnt ← cnt − 1 each cycle; returns to IDLE when cnt reaches 0.
  - Start_EX while BUSY: ignored, cnt not reloaded (the MD stall prevents this in legal streams).
- Register $0 never causes a data stall, even with RegWrite set.

## Timing
- Stall outputs have zero latency: same cycle as the causing inputs.
- Start_EX sampled at edge t → Busy high for exactly N cycles (t+1 … t+N), low after edge t+N.
- An MD_ID instruction behind a mult/div stalls N+1 cycles total (the Start cycle plus N busy cycles) and leaves ID in the cycle Busy first reads 0.
- Reset (async): cnt = 0, Busy = 0, Stall_Cnt = 0 immediately; while reset is high, En_PC = 1, En_IF_ID = 1 and Clr_ID_EX = 0 regardless of inputs. Reset during BUSY aborts the operation without completing the count.
- Start_EX and reset released in the same cycle: the Start is sampled at the first edge after release.

## Configuration
- STALL_PERF_EN defined: Stall_Cnt increments by 1 at each rising edge where stall = 1 and reset = 0, wraps from 2^32−1 to 0.
- STALL_PERF_EN undefined: no counter register; Stall_Cnt is constant 0. The port list is identical in both builds.

## Test plan
- Load-use: A3_EX = 8, RegWrite_EX = 1, Tnew_EX = 2, Rs_ID = 8, Tuse_rs_ID = 1 → En_PC = En_IF_ID = 0, Clr_ID_EX = 1; change Tuse to 2 → no stall.
- $0 and unused operand: A3_EX = 0 with Rs_ID = 0, and Tuse_rt_ID = 3 with a matching rt → no stall in both cases.
- Mult then mfhi: Start_EX = 1, MDOp_EX = 0, MD_ID = 1 → stall in the Start cycle plus 5 cycles; Busy high for 5 cycles; released in cycle 7.
- Div with a non-MD instruction in ID: MDOp_EX = 1 → Busy high for 10 cycles, En_PC stays 1 throughout.
- Reset at busy cycle 3 of a div → Busy = 0 and cnt = 0 immediately; stall outputs inactive; the next Start loads a fresh count.
- STALL_PERF_EN build: 3 load-use stalls plus one mult→mfhi sequence (6 stalls) → Stall_Cnt = 9; without the macro, Stall_Cnt = 0.
